bcd_decoder: RTL and testbench
==============================

BCD_DECODER -- requirements
Module: bcd_decoder

Interface
REQ-001 SHALL have parameter BINARY_LENGTH, default 128: width of the binary result in bits.
REQ-002 SHALL have parameter DECIMAL_LENGTH, default 39: number of 4-bit BCD digits accepted.
REQ-003 SHALL have port CLK, input, 1: single clock, all logic on the rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port BCD_data, input, DECIMAL_LENGTH*4: packed BCD operand; digit 0 is bits [3:0].
REQ-006 SHALL have port BCD_valid, input, 1: request to start a conversion of BCD_data.
REQ-007 SHALL have port busy, output, 1: a conversion is in progress and new requests are ignored.
REQ-008 SHALL have port binary_data, output, BINARY_LENGTH: converted unsigned binary value.
REQ-009 SHALL have port binary_ready, output, 1: one-cycle pulse when binary_data is valid.
REQ-010 SHALL have port BCD_error, output, 1: invalid digit or overflow, valid with binary_ready.

Function
REQ-011 SHALL implement reverse double-dabble over a shift register of DECIMAL_LENGTH*4 + BINARY_LENGTH bits, BCD field upper and binary field lower.
REQ-012 SHALL use FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE: busy=0; BCD_valid=1 on an edge loads BCD_data into the BCD field, clears the binary field and the iteration counter, then moves to SHIFT.
REQ-014 SHIFT: each cycle shifts the whole register right by 1, then subtracts 3 from every BCD digit whose value is >= 8; busy=1.
REQ-015 SHIFT SHALL run exactly BINARY_LENGTH cycles, counted with a counter of clog2(BINARY_LENGTH+1) bits, then move to DONE.
REQ-016 DONE: binary_ready=1 for exactly one cycle, binary_data = binary field, then return to IDLE.
REQ-017 Latency from the accepting edge to binary_ready high SHALL be BINARY_LENGTH+1 cycles; throughput is one conversion per BINARY_LENGTH+2 cycles.
REQ-018 binary_data SHALL hold its last result, unchanged, until the next DONE.
REQ-019 BCD_valid during SHIFT or DONE SHALL be ignored, with no queuing.
REQ-020 BCD_valid held high SHALL start a new conversion on the first IDLE cycle.
REQ-021 A value above 2^BINARY_LENGTH-1 SHALL yield the low BINARY_LENGTH bits of the value (modulo).

Reset
REQ-022 RST=1 SHALL, on the clock edge, force IDLE, busy=0, binary_ready=0, BCD_error=0, binary_data=0, and clear the counter and shift register.
REQ-023 RST in any state, including mid-SHIFT, SHALL abort the conversion with no binary_ready pulse.
REQ-024 RST SHALL take priority over a simultaneous BCD_valid.

Configuration
REQ-025 With macro BCD_DECODER_CHECK_EN defined, an input digit > 9 at load SHALL set a sticky error flag for that conversion.
REQ-026 With the macro defined, a nonzero BCD field after the last SHIFT cycle (overflow) SHALL also set the flag.
REQ-027 With the macro defined, BCD_error SHALL equal the flag during DONE and 0 otherwise.
REQ-028 Without the macro, BCD_error SHALL be tied to 0 and no check logic synthesized; the port list stays identical.

Structure
REQ-029 Package bcd_pkg SHALL hold the FSM state encoding, the digit width constant (4) and the correction constants (threshold 8, subtrahend 3).
REQ-030 Sub-module bcd_digit_correct (combinational, one 4-bit digit in, one out) SHALL be instantiated DECIMAL_LENGTH times via generate.

Verification
REQ-031 BCD_data=0x54, BCD_valid pulsed -> binary_ready after 129 cycles, binary_data=54, BCD_error=0.
REQ-032 BCD_data=0 -> binary_data=0; all 39 digits = 9 -> BCD_error=1 with macro, binary_data=(10^39-1) mod 2^128.
REQ-033 Digit 0 = 0xA with macro -> BCD_error=1 at binary_ready; without macro -> BCD_error=0.
REQ-034 BCD_valid pulsed during SHIFT -> ignored; exactly one binary_ready pulse; busy=1 throughout.
REQ-035 RST asserted at SHIFT cycle 50 -> no binary_ready, all outputs 0 next cycle; a fresh 0x99 then yields 99.
REQ-036 BCD_valid held high -> back-to-back results every 130 cycles, binary_data stable between pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// Package: bcd_pkg
// Shared definitions for the BCD-to-binary decoder:
//   state_t      FSM state encoding (IDLE, SHIFT, DONE)
//   DIGIT_W      width of one BCD digit
//   CORR_THRESH  digit value at or above which a correction is applied
//   CORR_SUB     amount subtracted from a digit that needs correction
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] CORR_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_correct.sv
// Module: bcd_digit_correct
// Combinational correction step of reverse double-dabble for one BCD digit:
// after a right shift, a digit of 8 or more has received a carried-in 8 that
// is worth 5 in decimal, so 3 is subtracted.
// Ports:
//   i_digit  BCD digit after the shift
//   o_digit  corrected digit
module bcd_digit_correct
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = (i_digit >= CORR_THRESH) ? (i_digit - CORR_SUB) : i_digit;
    end

endmodule

// File: rtl/bcd_decoder.sv
// Module: bcd_decoder
// Multi-cycle BCD-to-binary converter using reverse double-dabble. The shift
// register holds the BCD operand in its upper field and collects the binary
// result in its lower field; BINARY_LENGTH shift/correct steps are performed.
// Values that do not fit in BINARY_LENGTH bits wrap modulo 2^BINARY_LENGTH.
// Optional feature: define BCD_DECODER_CHECK_EN to flag invalid input digits
// (> 9) and overflow on BCD_error; otherwise BCD_error is tied to 0.
// Ports:
//   CLK           clock, rising edge
//   RST           synchronous active-high reset
//   BCD_data      packed BCD operand, digit 0 in bits [3:0]
//   BCD_valid     start request, accepted only while idle
//   busy          conversion in progress
//   binary_data   last converted value, held until the next result
//   binary_ready  one-cycle pulse when binary_data is updated
//   BCD_error     invalid digit or overflow, valid with binary_ready
module bcd_decoder
    import bcd_pkg::*;
#(
    parameter int BINARY_LENGTH  = 128,
    parameter int DECIMAL_LENGTH = 39
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [DECIMAL_LENGTH*DIGIT_W-1:0]   BCD_data,
    input  logic                                BCD_valid,
    output logic                                busy,
    output logic [BINARY_LENGTH-1:0]            binary_data,
    output logic                                binary_ready,
    output logic                                BCD_error
);

    localparam int BCD_W = DECIMAL_LENGTH * DIGIT_W;
    localparam int SR_W  = BCD_W + BINARY_LENGTH;
    localparam int CNT_W = $clog2(BINARY_LENGTH + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BINARY_LENGTH - 1);

    state_t                   r_state;
    logic [SR_W-1:0]          r_sr;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_busy;
    logic                     r_ready;
    logic [BINARY_LENGTH-1:0] r_data;

    logic [SR_W-1:0]          w_shifted;
    logic [BCD_W-1:0]         w_bcd_next;
    logic [SR_W-1:0]          w_sr_next;

    assign w_shifted = r_sr >> 1;

    // Correct every BCD digit of the shifted register in parallel.
    for (genvar g = 0; g < DECIMAL_LENGTH; g++) begin : g_digit
        bcd_digit_correct u_digit_correct (
            .i_digit (w_shifted[BINARY_LENGTH + g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_bcd_next[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign w_sr_next = {w_bcd_next, w_shifted[BINARY_LENGTH-1:0]};

`ifdef BCD_DECODER_CHECK_EN
    logic r_flag;
    logic r_error;
    logic w_bad_digit;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DECIMAL_LENGTH; i++) begin
            if (BCD_data[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
`ifdef BCD_DECODER_CHECK_EN
            r_flag  <= 1'b0;
            r_error <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
`ifdef BCD_DECODER_CHECK_EN
            r_error <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (BCD_valid) begin
                        r_sr    <= {BCD_data, {BINARY_LENGTH{1'b0}}};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
`ifdef BCD_DECODER_CHECK_EN
                        r_flag  <= w_bad_digit;
`endif
                    end
                end
                SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_data  <= r_sr[BINARY_LENGTH-1:0];
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
`ifdef BCD_DECODER_CHECK_EN
                    // Anything left in the BCD field did not fit in the result.
                    r_error <= r_flag | (|r_sr[SR_W-1:BINARY_LENGTH]);
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign binary_ready = r_ready;
    assign binary_data  = r_data;

`ifdef BCD_DECODER_CHECK_EN
    assign BCD_error = r_error;
`else
    assign BCD_error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_decoder.sv
// Testbench for bcd_decoder: directed vectors, expected results queued at the
// accepting edge and checked by an independent monitor on binary_ready.
module tb_bcd_decoder;

    localparam int BL  = 128;
    localparam int DL  = 39;
    localparam int LAT = BL + 1;
`ifdef BCD_DECODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            CLK;
    logic            RST;
    logic [DL*4-1:0] BCD_data;
    logic            BCD_valid;
    logic            busy;
    logic [BL-1:0]   binary_data;
    logic            binary_ready;
    logic            BCD_error;

    typedef struct {
        logic [BL-1:0] data;
        logic          err;
        int            t_rdy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_cnt  = 0;

    bcd_decoder #(
        .BINARY_LENGTH  (BL),
        .DECIMAL_LENGTH (DL)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .BCD_data     (BCD_data),
        .BCD_valid    (BCD_valid),
        .busy         (busy),
        .binary_data  (binary_data),
        .binary_ready (binary_ready),
        .BCD_error    (BCD_error)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BL-1:0] act, input logic [BL-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every binary_ready pulse must match the oldest queued expectation.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (binary_ready === 1'b1) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ready", BL'(1), BL'(0));
            end else begin
                e = sb.pop_front();
                check("data", binary_data, e.data);
                check("error", BL'(BCD_error), BL'(e.err));
                check("latency", BL'(cyc), BL'(e.t_rdy));
            end
        end
    end

    task automatic issue(input logic [DL*4-1:0] d, input logic [BL-1:0] exp_d, input logic exp_e,
                         output int t_acc);
        exp_t e;
        @(negedge CLK);
        BCD_data  = d;
        BCD_valid = 1'b1;
        @(posedge CLK);
        #1;
        t_acc   = cyc;
        e.data  = exp_d;
        e.err   = exp_e;
        e.t_rdy = cyc + LAT;
        sb.push_back(e);
        @(negedge CLK);
        BCD_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", BL'(sb.size()), BL'(0));
            sb.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            t0;
        int            r0;
        int            bad;
        logic [DL*4-1:0] d;
        logic [BL-1:0] m;
        exp_t          e;

        RST       = 1'b1;
        BCD_valid = 1'b0;
        BCD_data  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", BL'(busy), BL'(0));
        check("rst_ready", BL'(binary_ready), BL'(0));
        check("rst_error", BL'(BCD_error), BL'(0));
        check("rst_data", binary_data, BL'(0));
        RST = 1'b0;

        issue(156'h54, BL'(54), 1'b0, t0);
        drain(300);
        issue(156'h0, BL'(0), 1'b0, t0);
        drain(300);

        // All 39 digits 9: value wraps modulo 2^128 and overflows the field.
        m = '0;
        for (int i = 0; i < DL; i++) begin
            d[i*4 +: 4] = 4'd9;
            m = m * 10 + 9;
        end
        issue(d, m, CHK, t0);
        drain(300);

        // Digit 0 = 0xA: no correction triggers, raw value 10 comes through.
        issue(156'hA, BL'(10), CHK, t0);
        drain(300);

        // BCD_valid pulsed mid-conversion must be ignored.
        r0  = rdy_cnt;
        bad = 0;
        issue(156'h12, BL'(12), 1'b0, t0);
        while (cyc <= t0 + BL) begin
            if (busy !== 1'b1) bad++;
            if (cyc == t0 + 20) begin
                BCD_data  = 156'h77;
                BCD_valid = 1'b1;
            end else begin
                BCD_valid = 1'b0;
            end
            @(negedge CLK);
        end
        BCD_valid = 1'b0;
        check("busy_during_shift", BL'(bad), BL'(0));
        drain(300);
        while (cyc < t0 + 320) @(negedge CLK);
        check("single_ready", BL'(rdy_cnt - r0), BL'(1));

        // Reset at shift cycle 50, together with a start request.
        issue(156'h31, BL'(31), 1'b0, t0);
        while (cyc < t0 + 50) @(negedge CLK);
        RST       = 1'b1;
        BCD_valid = 1'b1;
        sb.delete();
        r0 = rdy_cnt;
        @(negedge CLK);
        check("abort_busy", BL'(busy), BL'(0));
        check("abort_ready", BL'(binary_ready), BL'(0));
        check("abort_error", BL'(BCD_error), BL'(0));
        check("abort_data", binary_data, BL'(0));
        RST       = 1'b0;
        BCD_valid = 1'b0;
        repeat (200) @(negedge CLK);
        check("no_ready_after_abort", BL'(rdy_cnt - r0), BL'(0));
        issue(156'h99, BL'(99), 1'b0, t0);
        drain(300);

        // BCD_valid held high: back-to-back conversions every BL+2 cycles.
        @(negedge CLK);
        BCD_data  = 156'h123;
        BCD_valid = 1'b1;
        @(posedge CLK);
        #1;
        t0 = cyc;
        e.err = 1'b0;
        e.data = BL'(123); e.t_rdy = t0 + LAT;           sb.push_back(e);
        e.data = BL'(456); e.t_rdy = t0 + LAT + BL + 2;  sb.push_back(e);
        e.data = BL'(789); e.t_rdy = t0 + LAT + 2*(BL + 2); sb.push_back(e);
        bad = 0;
        while (cyc < t0 + LAT + 2*(BL + 2)) begin
            @(negedge CLK);
            if (cyc == t0) BCD_data = 156'h456;
            if (cyc == t0 + BL + 2) BCD_data = 156'h789;
            if (cyc == t0 + 2*(BL + 2) + 1) BCD_valid = 1'b0;
            if (cyc >= t0 + LAT && cyc < t0 + LAT + 2*(BL + 2)) begin
                m = (cyc >= t0 + LAT + BL + 2) ? BL'(456) : BL'(123);
                if (binary_data !== m) bad++;
            end
        end
        BCD_valid = 1'b0;
        check("hold_stable", BL'(bad), BL'(0));
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
